rr_arb4: RTL and testbench

Four-requester round-robin arbiter that shares a single downstream resource (such as the 4-to-2 encoded select path) between requesters. It accepts a 4-bit request vector and issues one registered one-hot grant plus its 2-bit encoded index. A grant is held until the owner drops its request or a hold limit expires. Priority rotates so that the most recently served requester becomes lowest priority.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/rr_arb4.sv | 112 +++++++++++
 tb/tb_rr_arb4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 4-way round-robin arbiter
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority winner scan with one-hot and encoded result
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   logic [IDX_W-1:0] idx;

   // Scan from lowest to highest priority so the last hit (offset 0 = ptr) wins.
   always_comb begin
      win     = '0;
      win_idx = '0;
      idx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ptr + IDX_W'(k);
         if (req[idx]) begin
            win      = '0;
            win[idx] = 1'b1;
            win_idx  = idx;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-requester round-robin arbiter with per-grant hold limit
module rr_arb4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   localparam logic [7:0] CNT_LIM = 8'(HOLD_MAX - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             timeout_q, timeout_d;

   logic [N_REQ-1:0] pick_req;
   logic [IDX_W-1:0] pick_ptr;
   logic [N_REQ-1:0] win;
   logic [IDX_W-1:0] win_idx;
   logic             win_any;
   logic             owner_req;

   // In GRANT the picker always sees the post-release pointer; its result is
   // only consumed when the current grant is actually released.
   always_comb begin
      owner_req = req[gnt_idx_q];
      pick_ptr  = (state_q == GRANT) ? gnt_idx_q + IDX_W'(1) : ptr_q;
      pick_req  = (state_q == GRANT && !owner_req) ? (req & ~gnt_q) : req;
   end

   rr_pick u_pick (
      .req     (pick_req),
      .ptr     (pick_ptr),
      .win     (win),
      .win_idx (win_idx),
      .any     (win_any)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               gnt_d     = win;
               gnt_idx_d = win_idx;
               cnt_d     = '0;
               state_d   = GRANT;
            end
         end
         GRANT: begin
            if (owner_req && (cnt_q < CNT_LIM)) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               ptr_d     = pick_ptr;
               timeout_d = owner_req;
               cnt_d     = '0;
               if (win_any) begin
                  gnt_d     = win;
                  gnt_idx_d = win_idx;
               end else begin
                  gnt_d     = '0;
                  gnt_idx_d = '0;
                  state_d   = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = |gnt_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - directed scoreboard bench for rr_arb4 with HOLD_MAX=4
module tb_rr_arb4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      string      tag;
      logic [3:0] gnt;
      logic       to;
   } exp_t;

   exp_t sb[$];

   rr_arb4 #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] first_from(input logic [3:0] r, input logic [1:0] p);
      logic [3:0] res;
      logic [1:0] i;
      res = '0;
      for (int k = 0; k < 4; k++) begin
         i = p + 2'(k);
         if (r[i] && res == 4'b0000) res = 4'b0001 << i;
      end
      return res;
   endfunction

   task automatic check_out(input string tag, input logic [3:0] eg, input logic et);
      checks++;
      assert (gnt === eg) else begin
         failures++;
         $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
      end
      checks++;
      assert (gnt_vld === (|eg)) else begin
         failures++;
         $error("FAIL %s gnt_vld observed=%b expected=%b", tag, gnt_vld, |eg);
      end
      checks++;
      assert (gnt_idx === enc(eg)) else begin
         failures++;
         $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, enc(eg));
      end
      checks++;
      assert (timeout === et) else begin
         failures++;
         $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, et);
      end
   endtask

   // Drive req just after an edge, expect the result one edge later.
   task automatic drive(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic et);
      exp_t e;
      req = r;
      sb.push_back('{tag: tag, gnt: eg, to: et});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_out(e.tag, e.gnt, e.to);
   endtask

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         checks++;
         assert (gnt == 4'b0000 || $onehot(gnt)) else begin
            failures++;
            $error("FAIL onehot gnt observed=%b expected=onehot_or_zero", gnt);
         end
         checks++;
         assert (!gnt_vld || gnt_idx === enc(gnt)) else begin
            failures++;
            $error("FAIL idx_consistency gnt_idx observed=%0d expected=%0d", gnt_idx, enc(gnt));
         end
      end
   end

   initial begin
      logic [3:0] r;
      logic [3:0] w;
      logic [1:0] p;

      rst_n = 1'b0;
      req   = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset", 4'b0000, 1'b0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      drive("rot0", 4'b1111, 4'b0001, 1'b0);
      drive("rot1", 4'b1110, 4'b0010, 1'b0);
      drive("rot2", 4'b1101, 4'b0100, 1'b0);
      drive("rot3", 4'b1011, 4'b1000, 1'b0);
      drive("rot_wrap", 4'b0111, 4'b0001, 1'b0);
      drive("rot_idle", 4'b0000, 4'b0000, 1'b0);

      drive("single_gnt", 4'b0100, 4'b0100, 1'b0);
      drive("single_drop", 4'b0000, 4'b0000, 1'b0);

      drive("hold_c0", 4'b0011, 4'b0001, 1'b0);
      drive("hold_c1", 4'b0011, 4'b0001, 1'b0);
      drive("hold_c2", 4'b0011, 4'b0001, 1'b0);
      drive("hold_c3", 4'b0011, 4'b0001, 1'b0);
      drive("hold_limit", 4'b0011, 4'b0010, 1'b1);
      drive("hold_after", 4'b0011, 4'b0010, 1'b0);

      drive("sole_gnt", 4'b0001, 4'b0001, 1'b0);
      drive("sole_c1", 4'b0001, 4'b0001, 1'b0);
      drive("sole_c2", 4'b0001, 4'b0001, 1'b0);
      drive("sole_c3", 4'b0001, 4'b0001, 1'b0);
      drive("sole_limit", 4'b0001, 4'b0001, 1'b1);
      drive("sole_after", 4'b0001, 4'b0001, 1'b0);

      drive("b2b_to1", 4'b0010, 4'b0010, 1'b0);
      drive("b2b_to2", 4'b1100, 4'b0100, 1'b0);

      drive("tog_own0", 4'b0001, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         r = {3'($urandom_range(0, 7)), 1'b1};
         drive("tog_hold", r, 4'b0001, 1'b0);
      end
      r = {3'($urandom_range(0, 7)), 1'b1};
      w = first_from(r, 2'd1);
      drive("tog_limit", r, w, 1'b1);
      drive("tog_idle", 4'b0000, 4'b0000, 1'b0);
      p = enc(w) + 2'd1;

      drive("pre_reset", 4'b1111, first_from(4'b1111, p), 1'b0);
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_hold", 4'b0000, 1'b0);
      rst_n = 1'b1;
      drive("post_reset", 4'b1111, 4'b0001, 1'b0);
      drive("post_reset_drop", 4'b0000, 4'b0000, 1'b0);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
